// File: rtl/hack_mmio_mem_if.sv
// CPU data port bundle: write enable, write data and address from the CPU, read data back.
// Ports: writeM, outM, addressM (CPU -> memory); inM (memory -> CPU).
// master = CPU side, slave = memory side.
interface hack_mmio_mem_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 16
);
  logic              writeM;
  logic [WIDTH-1:0]  outM;
  logic [ADDR_W-1:0] addressM;
  logic [WIDTH-1:0]  inM;

  modport master (output writeM, output outM, output addressM, input inM);
  modport slave  (input writeM, input outM, input addressM, output inM);
endinterface

// File: rtl/hack_mmio_mem.sv
// Hack data memory: RAM of DEPTH words plus memory-mapped output registers,
// synchronised input registers and a time-multiplexed display scanner.
// Ports: clk, reset (sync, active-high), cpu (writeM/outM/addressM -> inM),
//   sw_in (async board inputs), out_bus/out_upd (output registers, write pulses),
//   disp_sel/disp_val (scanned display channel). inM is combinational from address and state.
module hack_mmio_mem #(
  parameter int          WIDTH    = 16,
  parameter int          ADDR_W   = 16,
  parameter int          DEPTH    = 1024,
  parameter int          NUM_OUT  = 3,
  parameter int          NUM_IN   = 2,
  parameter int unsigned OUT_BASE = 32'h4000,
  parameter int unsigned IN_BASE  = 32'h6000,
  parameter int          SCAN_DIV = 4,
  localparam int         SEL_W    = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  hack_mmio_mem_if.slave           cpu,
  input  logic [NUM_IN*WIDTH-1:0]  sw_in,
  output logic [NUM_OUT*WIDTH-1:0] out_bus,
  output logic [NUM_OUT-1:0]       out_upd,
  output logic [SEL_W-1:0]         disp_sel,
  output logic [WIDTH-1:0]         disp_val
);

  localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IN_W   = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int SC_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [31:0] DEPTH32    = 32'(DEPTH);
  localparam logic [31:0] OUT_LO     = 32'(OUT_BASE);
  localparam logic [31:0] OUT_HI     = 32'(OUT_BASE) + 32'(NUM_OUT);
  localparam logic [31:0] IN_LO      = 32'(IN_BASE);
  localparam logic [31:0] IN_HI      = 32'(IN_BASE) + 32'(NUM_IN);
  localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(SCAN_DIV - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_OUT - 1);

  logic [WIDTH-1:0] ram   [DEPTH];
  logic [WIDTH-1:0] out_q [NUM_OUT];
  logic [WIDTH-1:0] sync1 [NUM_IN];
  logic [WIDTH-1:0] sync_q[NUM_IN];
  logic [SC_W-1:0]  scan_cnt;

  // Decode in a 32-bit space so base+count never wraps for any ADDR_W <= 31.
  logic [31:0]       addr_ext;
  logic [31:0]       out_off;
  logic [31:0]       in_off;
  logic              is_ram;
  logic              is_out;
  logic              is_in;
  logic [RAM_AW-1:0] ram_idx;
  logic [SEL_W-1:0]  out_idx;
  logic [IN_W-1:0]   in_idx;

  assign addr_ext = 32'(cpu.addressM);
  assign out_off  = addr_ext - OUT_LO;
  assign in_off   = addr_ext - IN_LO;
  // Priority RAM > OUT > IN resolves overlapping regions.
  assign is_ram   = addr_ext < DEPTH32;
  assign is_out   = !is_ram && (addr_ext >= OUT_LO) && (addr_ext < OUT_HI);
  assign is_in    = !is_ram && !is_out && (addr_ext >= IN_LO) && (addr_ext < IN_HI);
  assign ram_idx  = addr_ext[RAM_AW-1:0];
  assign out_idx  = out_off[SEL_W-1:0];
  assign in_idx   = in_off[IN_W-1:0];

  always_comb begin
    cpu.inM = '0;
    if (is_ram)      cpu.inM = ram[ram_idx];
    else if (is_out) cpu.inM = out_q[out_idx];
    else if (is_in)  cpu.inM = sync_q[in_idx];
  end

  // RAM has no reset so it maps onto block RAM; writes proceed even during reset.
  always_ff @(posedge clk) begin
    if (cpu.writeM && is_ram) ram[ram_idx] <= cpu.outM;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_OUT; k++) out_q[k] <= '0;
      out_upd <= '0;
    end else begin
      out_upd <= '0;
      if (cpu.writeM && is_out) begin
        out_q[out_idx]   <= cpu.outM;
        out_upd[out_idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_IN; k++) begin
        sync1[k]  <= '0;
        sync_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_IN; k++) begin
        sync1[k]  <= sw_in[k*WIDTH +: WIDTH];
        sync_q[k] <= sync1[k];
      end
    end
  end

  // Scanner: disp_sel steps once per SCAN_DIV clocks, wrapping at NUM_OUT-1
  // explicitly so non-power-of-two channel counts never select a missing register.
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt <= '0;
      disp_sel <= '0;
      disp_val <= '0;
    end else begin
      disp_val <= out_q[disp_sel];
      if (scan_cnt == SC_LAST) begin
        scan_cnt <= '0;
        disp_sel <= (disp_sel == SEL_LAST) ? '0 : disp_sel + 1'b1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
    assign out_bus[k*WIDTH +: WIDTH] = out_q[k];
  end

endmodule
